// File: rtl/ks_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with one prefix level per stage.
// Each stage has a valid/ready handshake and collapses bubbles when the output is stalled.
`timescale 1ns/1ps
module ks_adder_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = LEVELS + 2;
  localparam int OSTG   = NSTG - 1;

  logic [NSTG-1:0]  vld_q;
  logic [NSTG-1:0]  vld_d;
  logic [NSTG-1:0]  adv;

  logic [WIDTH-1:0] g_q    [0:LEVELS];
  logic [WIDTH-1:0] g_d    [0:LEVELS];
  logic [WIDTH-1:0] rawp_q [0:LEVELS];
  logic [WIDTH-1:0] rawp_d [0:LEVELS];
  logic             c0_q   [0:LEVELS];
  logic             c0_d   [0:LEVELS];
  logic [WIDTH-1:0] p_q    [0:LEVELS-1];
  logic [WIDTH-1:0] p_d    [0:LEVELS-1];

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  logic [WIDTH-1:0] p_in;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Stage 0: subtraction is A + ~B + 1, and the carry-in is folded into bit 0's generate.
  assign b_eff     = in_sub ? ~in_b : in_b;
  assign c0_in     = in_sub | in_cin;
  assign p_in      = in_a ^ b_eff;
  assign rawp_d[0] = p_in;
  assign p_d[0]    = p_in;
  assign c0_d[0]   = c0_in;
  assign g_d[0]    = (in_a & b_eff) | {{(WIDTH-1){1'b0}}, p_in[0] & c0_in};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int               SPAN = 1 << (k - 1);
    localparam logic [WIDTH-1:0] LOW  = ~({WIDTH{1'b1}} << SPAN);

    // Bits below SPAN have no partner at this level and pass straight through.
    assign g_d[k]    = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << SPAN));
    assign rawp_d[k] = rawp_q[k-1];
    assign c0_d[k]   = c0_q[k-1];

    if (k < LEVELS) begin : g_prop
      assign p_d[k] = p_q[k-1] & ((p_q[k-1] << SPAN) | LOW);
    end
  end

  // After the last level G[i] is the carry out of bit i.
  assign carry  = {g_q[LEVELS], c0_q[LEVELS]};
  assign sum_d  = rawp_q[LEVELS] ^ carry[WIDTH-1:0];
  assign cout_d = carry[WIDTH];
  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

  always_comb begin
    adv[OSTG] = out_ready | ~vld_q[OSTG];
    for (int k = OSTG - 1; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~vld_q[k];
    end
  end

  assign vld_d    = {vld_q[NSTG-2:0], in_valid};
  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q <= (vld_d & adv) | (vld_q & ~adv);
      if (adv[OSTG]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (adv[k]) begin
        g_q[k]    <= g_d[k];
        rawp_q[k] <= rawp_d[k];
        c0_q[k]   <= c0_d[k];
      end
    end

    if (k < LEVELS) begin : g_preg
      always_ff @(posedge clk) begin
        if (adv[k]) begin
          p_q[k] <= p_d[k];
        end
      end
    end
  end

  assign out_valid = vld_q[OSTG];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: a 32-bit instance for directed and random traffic,
// plus 2/5/64-bit instances under random valid/ready toggling.
`timescale 1ns/1ps
module tb_ks_adder_pipe;

  localparam int LAT32 = 7;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int          checks = 0;
  int          errors = 0;
  int          t3Stalls = 0;
  bit          t3Phase = 0;
  bit          t5Go = 0;
  logic [65:0] sb [$];
  logic [65:0] expMain;

  ks_adder_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard so the bench can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: {ovf, cout, sum} for a w-bit add/subtract.
  function automatic logic [65:0] refModel(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
    logic [64:0] mask, bb, full;
    logic [63:0] s;
    logic [6:0]  top, msb;
    logic        co, ov;
    top  = 7'(w);
    msb  = 7'(w - 1);
    mask = (65'd1 << w) - 65'd1;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = ({1'b0, a} & mask) + bb + {64'd0, (sub ? 1'b1 : cin)};
    s    = full[63:0] & mask[63:0];
    co   = full[top];
    ov   = (a[msb] == bb[msb]) && (s[msb] != a[msb]);
    return {ov, co, s};
  endfunction

  // Monitor for the 32-bit DUT: bubble-collapse property, output scoreboard, input capture.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) checkOutput("bubble_collapse_occupancy", 64'(sb.size()), 64'(LAT32));
      if (t3Phase && !in_ready) t3Stalls++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          expMain = sb.pop_front();
          checkOutput("sum", 64'(out_sum), expMain[63:0]);
          checkOutput("cout", 64'(out_cout), 64'(expMain[64]));
          checkOutput("ovf", 64'(out_ovf), 64'(expMain[65]));
        end
      end
      if (in_valid && in_ready) sb.push_back(refModel(32, 64'(in_a), 64'(in_b), in_cin, in_sub));
    end
  end

  // Extra widths, each with its own random traffic and scoreboard.
  for (genvar gi = 0; gi < 3; gi++) begin : gW
    localparam int W  = (gi == 0) ? 2 : (gi == 1) ? 5 : 64;
    localparam int NS = $clog2(W) + 2;

    logic         rValid, rInReady, rCin, rSub, rOutValid, rReady, rCout, rOvf;
    logic [W-1:0] rA, rB, rSum;
    logic [65:0]  q [$];
    logic [65:0]  expW;
    bit           done;

    ks_adder_pipe #(.WIDTH(W)) dutW (
      .clk(clk), .rst_n(rst_n),
      .in_valid(rValid), .in_ready(rInReady),
      .in_a(rA), .in_b(rB), .in_cin(rCin), .in_sub(rSub),
      .out_valid(rOutValid), .out_ready(rReady),
      .out_sum(rSum), .out_cout(rCout), .out_ovf(rOvf)
    );

    // Random valid/ready toggling, then a bounded drain.
    initial begin
      int n;
      done = 0; rValid = 0; rReady = 1; rA = '0; rB = '0; rCin = 0; rSub = 0;
      wait (t5Go);
      for (int i = 0; i < 1200; i++) begin
        @(posedge clk); #1;
        rValid = 1'($urandom_range(0, 1));
        rReady = ($urandom_range(0, 3) != 0);
        rA     = W'({$urandom(), $urandom()});
        rB     = W'({$urandom(), $urandom()});
        rCin   = 1'($urandom_range(0, 1));
        rSub   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      rValid = 0; rReady = 1;
      n = 0;
      while ((q.size() != 0 || rOutValid) && n < 100) begin
        @(posedge clk); #1; n++;
      end
      checkOutput($sformatf("w%0d_drain", W), 64'(q.size()), 64'd0);
      done = 1;
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (!rInReady) checkOutput($sformatf("w%0d_bubble", W), 64'(q.size()), 64'(NS));
        if (rOutValid && rReady) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("w%0d_unexpected", W), 64'(rOutValid), 64'd0);
          end else begin
            expW = q.pop_front();
            checkOutput($sformatf("w%0d_sum", W), 64'(rSum), expW[63:0]);
            checkOutput($sformatf("w%0d_cout", W), 64'(rCout), 64'(expW[64]));
            checkOutput($sformatf("w%0d_ovf", W), 64'(rOvf), 64'(expW[65]));
          end
        end
        if (rValid && rInReady) q.push_back(refModel(W, 64'(rA), 64'(rB), rCin, rSub));
      end
    end
  end

  // Present one operation and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!in_ready && n < 200);
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Wait for the next result, checking latency from the accepting edge and the exact values.
  task automatic expectResult(input string tag, input logic [31:0] s, input logic co, input logic ov);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(LAT32 - 1));
    checkOutput({tag, "_sum"}, 64'(out_sum), 64'(s));
    checkOutput({tag, "_cout"}, 64'(out_cout), 64'(co));
    checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(ov));
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checkOutput({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc, n;
    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_sum", 64'(out_sum), 64'd0);
    checkOutput("reset_out_cout", 64'(out_cout), 64'd0);
    checkOutput("reset_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // T1: wrap-around add and latency
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    expectResult("t1", 32'h0, 1'b1, 1'b0);
    waitIdle("t1");

    // T2: subtraction with carry-in ignored
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    expectResult("t2a", 32'h8000_0000, 1'b0, 1'b1);
    waitIdle("t2a");
    applyStimulus(32'd5, 32'd5, 1'b0, 1'b1);
    expectResult("t2b", 32'h0, 1'b1, 1'b0);
    waitIdle("t2b");

    // T3: back-to-back random stream with the output always ready
    t3Phase = 1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    t3Phase = 0;
    waitIdle("t3");
    checkOutput("t3_in_ready_stalls", 64'(t3Stalls), 64'd0);

    // T4: output stalled while feeding; pipe must absorb exactly 7 ops
    out_ready = 0; acc = 0;
    in_valid = 1; in_a = $urandom(); in_b = $urandom(); in_cin = 1'($urandom_range(0, 1)); in_sub = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk); #1;
      in_a = $urandom(); in_b = $urandom(); in_cin = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 0;
    checkOutput("t4_accepted", 64'(acc), 64'(LAT32));
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("t4_hold_sum", 64'(out_sum), sb[0][63:0]);
      checkOutput("t4_hold_cout", 64'(out_cout), 64'(sb[0][64]));
      checkOutput("t4_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    waitIdle("t4");

    // T6: asynchronous reset with ops in flight and a result waiting at the output
    out_ready = 0;
    for (int k = 0; k < 5; k++) applyStimulus(32'h100 + 32'(k), 32'h1000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_pre_valid", 64'(out_valid), 64'd1);
    checkOutput("t6_pre_sum", 64'(out_sum), 64'h1100);
    rst_n = 0;
    sb.delete();
    #1;
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_sum", 64'(out_sum), 64'd0);
    checkOutput("t6_rst_cout", 64'(out_cout), 64'd0);
    checkOutput("t6_rst_ovf", 64'(out_ovf), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t6_no_stale", 64'(out_valid), 64'd0);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    applyStimulus(32'h0, 32'h1, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    waitIdle("t6");

    // T5: random valid/ready toggling on all widths at once
    t5Go = 1;
    for (int i = 0; i < 1200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = $urandom();
      in_b      = $urandom();
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    waitIdle("t5");
    n = 0;
    while (!(gW[0].done && gW[1].done && gW[2].done) && n < 500) begin
      @(posedge clk); n++;
    end
    checkOutput("t5_widths_done", 64'({gW[0].done, gW[1].done, gW[2].done}), 64'h7);
    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
